// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, operand and pipeline-register types.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int ALN_W  = SIG_W + 3;
    localparam logic [EXP_W-1:0] BIAS    = 5'd15;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [15:0] POS_INF = 16'h7C00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  sig;
        logic              is_nan;
        logic              is_inf;
    } operand_t;

    typedef struct packed {
        logic              sign_big;
        logic              flag;
        logic [EXP_W-1:0]  exp_big;
        logic [SIG_W-1:0]  sig_big;
        logic [ALN_W-1:0]  sml_aln;
        logic              spec_vld;
        logic [15:0]       spec_val;
    } stage1_t;

    // Subnormals are flushed to zero here so nothing downstream sees them.
    function automatic operand_t unpack(input logic [15:0] raw);
        operand_t op;
        op.sign   = raw[15];
        op.exp    = raw[14:10];
        op.sig    = (raw[14:10] == '0) ? '0 : {1'b1, raw[9:0]};
        op.is_nan = (raw[14:10] == EXP_MAX) && (raw[9:0] != '0);
        op.is_inf = (raw[14:10] == EXP_MAX) && (raw[9:0] == '0);
        return op;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero count over an 11-bit significand plus guard/round/sticky.
// Purely combinational; all-zero input reports 14.
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [ALN_W-1:0] dat,
    output logic [4:0]       cnt
);

    always_comb begin
        cnt = 5'd14;
        for (int i = 0; i < ALN_W; i++) begin
            if (dat[i]) begin
                cnt = 5'(ALN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_adder.sv
// Two-stage binary16 adder, round-to-nearest-even, flush-to-zero.
// Latency 2 cycles, one operand pair per cycle, no backpressure.
module fp16_adder
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] numi1,
    input  logic [15:0] numi2,
    output logic [15:0] ans,
    output logic        sign1o,
    output logic        sign2o,
    output logic [4:0]  exp1o,
    output logic [4:0]  exp2o,
    output logic [4:0]  expdiffo,
    output logic        szo,
    output logic [4:0]  ra,
    output logic        flago,
    output logic [4:0]  lambdao,
    output logic [10:0] mro,
    output logic [4:0]  rexpo
);

    operand_t         op1, op2;
    logic             swap;
    logic             big_sign;
    logic [EXP_W-1:0] big_exp, sml_exp, diff;
    logic [SIG_W-1:0] big_sig, sml_sig;
    logic [ALN_W-1:0] sml_ext, sml_shr;
    logic             lost;
    stage1_t          s1_d, s1_q;

    always_comb begin
        op1 = unpack(numi1);
        op2 = unpack(numi2);
        // Ties keep numi1 as the larger operand.
        swap     = {op2.exp, op2.sig[FRAC_W-1:0]} > {op1.exp, op1.sig[FRAC_W-1:0]};
        big_sign = swap ? op2.sign : op1.sign;
        big_exp  = swap ? op2.exp  : op1.exp;
        big_sig  = swap ? op2.sig  : op1.sig;
        sml_exp  = swap ? op1.exp  : op2.exp;
        sml_sig  = swap ? op1.sig  : op2.sig;
        diff     = big_exp - sml_exp;

        // Oversized shifts shift everything out, leaving only the sticky bit.
        sml_ext = {sml_sig, 3'b000};
        sml_shr = sml_ext >> diff;
        lost    = |(sml_ext & ~(14'h3FFF << diff));

        s1_d.sign_big = big_sign;
        s1_d.flag     = op1.sign ^ op2.sign;
        s1_d.exp_big  = big_exp;
        s1_d.sig_big  = big_sig;
        s1_d.sml_aln  = {sml_shr[ALN_W-1:1], sml_shr[0] | lost};
        s1_d.spec_vld = op1.is_nan | op2.is_nan | op1.is_inf | op2.is_inf;
        if (op1.is_nan || op2.is_nan || (op1.is_inf && op2.is_inf && (op1.sign != op2.sign))) begin
            s1_d.spec_val = QNAN;
        end else if (op1.is_inf) begin
            s1_d.spec_val = {op1.sign, POS_INF[14:0]};
        end else begin
            s1_d.spec_val = {op2.sign, POS_INF[14:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            sign1o   <= 1'b0;
            sign2o   <= 1'b0;
            exp1o    <= '0;
            exp2o    <= '0;
            expdiffo <= '0;
            szo      <= 1'b0;
            ra       <= '0;
        end else begin
            s1_q     <= s1_d;
            sign1o   <= op1.sign;
            sign2o   <= op2.sign;
            exp1o    <= op1.exp;
            exp2o    <= op2.exp;
            expdiffo <= diff;
            szo      <= swap;
            ra       <= big_exp;
        end
    end

    logic [ALN_W:0]   sum;
    logic             carry;
    logic [4:0]       lz;
    logic [ALN_W-1:0] norm;
    logic [6:0]       exp_n, exp_f;
    logic [SIG_W-1:0] mant;
    logic             rnd;
    logic [SIG_W:0]   mant_r;
    logic [9:0]       frac_f;
    logic             ovf, unf;
    logic [15:0]      res;
    logic [4:0]       lam;

    fp16_lzc u_lzc (
        .dat (sum[ALN_W-1:0]),
        .cnt (lz)
    );

    always_comb begin
        // Magnitude ordering guarantees the subtraction never goes negative.
        if (s1_q.flag) begin
            sum = {1'b0, s1_q.sig_big, 3'b000} - {1'b0, s1_q.sml_aln};
        end else begin
            sum = {1'b0, s1_q.sig_big, 3'b000} + {1'b0, s1_q.sml_aln};
        end
        carry = sum[ALN_W];

        if (carry) begin
            norm  = {sum[ALN_W:2], sum[1] | sum[0]};
            exp_n = {2'b00, s1_q.exp_big} + 7'd1;
            lam   = 5'd0;
        end else begin
            norm  = sum[ALN_W-1:0] << lz;
            exp_n = {2'b00, s1_q.exp_big} - {2'b00, lz};
            lam   = lz;
        end

        mant   = norm[ALN_W-1:3];
        rnd    = norm[2] & (norm[1] | norm[0] | mant[0]);
        mant_r = {1'b0, mant} + {{SIG_W{1'b0}}, rnd};
        if (mant_r[SIG_W]) begin
            frac_f = mant_r[SIG_W-1:1];
            exp_f  = exp_n + 7'd1;
        end else begin
            frac_f = mant_r[FRAC_W-1:0];
            exp_f  = exp_n;
        end

        ovf = !exp_f[6] && (exp_f >= {2'b00, EXP_MAX});
        unf = exp_f[6] || (exp_f == 7'd0);

        res = {s1_q.sign_big, exp_f[4:0], frac_f};
        if (s1_q.spec_vld) begin
            res = s1_q.spec_val;
            lam = 5'd0;
        end else if (sum == '0) begin
            // Opposite-sign cancellation gives +0; like-signed zeros keep their sign.
            res = s1_q.flag ? 16'h0000 : {s1_q.sign_big, 15'h0000};
            lam = 5'd0;
        end else if (ovf) begin
            res = {s1_q.sign_big, POS_INF[14:0]};
            lam = 5'd0;
        end else if (unf) begin
            res = {s1_q.sign_big, 15'h0000};
            lam = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ans     <= '0;
            flago   <= 1'b0;
            lambdao <= '0;
            mro     <= '0;
            rexpo   <= '0;
        end else begin
            ans     <= res;
            flago   <= s1_q.flag;
            lambdao <= lam;
            mro     <= {|res[14:10], res[9:0]};
            rexpo   <= res[14:10];
        end
    end

endmodule

// File: tb/tb_fp16_adder.sv
// Directed-vector bench for fp16_adder: table of sums plus pipeline/reset sequences.
module tb_fp16_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] numi1, numi2;
    logic [15:0] ans;
    logic        sign1o, sign2o, szo, flago;
    logic [4:0]  exp1o, exp2o, expdiffo, ra, lambdao, rexpo;
    logic [10:0] mro;

    int checks = 0;
    int errors = 0;

    fp16_adder dut (
        .clk      (clk),
        .rst      (rst),
        .numi1    (numi1),
        .numi2    (numi2),
        .ans      (ans),
        .sign1o   (sign1o),
        .sign2o   (sign2o),
        .exp1o    (exp1o),
        .exp2o    (exp2o),
        .expdiffo (expdiffo),
        .szo      (szo),
        .ra       (ra),
        .flago    (flago),
        .lambdao  (lambdao),
        .mro      (mro),
        .rexpo    (rexpo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        flag;
        logic [4:0]  lam;
        logic        chk_lam;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {3'b000, ans, sign1o, sign2o, exp1o, exp2o, expdiffo, szo, ra,
                flago, lambdao, mro, rexpo};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{16'h3800, 16'h3800, 16'h3C00, 1'b0, 5'd0, 1'b1};
        vecs[1]  = '{16'h3C00, 16'hBC00, 16'h0000, 1'b1, 5'd0, 1'b0};
        vecs[2]  = '{16'h3C00, 16'hB800, 16'h3800, 1'b1, 5'd1, 1'b1};
        vecs[3]  = '{16'h3C00, 16'h1400, 16'h3C01, 1'b0, 5'd0, 1'b1};
        vecs[4]  = '{16'h3C00, 16'h1000, 16'h3C00, 1'b0, 5'd0, 1'b1};
        vecs[5]  = '{16'h3C01, 16'h1000, 16'h3C02, 1'b0, 5'd0, 1'b1};
        vecs[6]  = '{16'h3C00, 16'h0001, 16'h3C00, 1'b0, 5'd0, 1'b1};
        vecs[7]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0, 5'd0, 1'b1};
        vecs[8]  = '{16'h7C00, 16'hFC00, 16'h7E00, 1'b1, 5'd0, 1'b1};
        vecs[9]  = '{16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 5'd0, 1'b1};
        vecs[10] = '{16'h8000, 16'h8000, 16'h8000, 1'b0, 5'd0, 1'b0};
        vecs[11] = '{16'h3FFF, 16'h1000, 16'h4000, 1'b0, 5'd0, 1'b1};
        vecs[12] = '{16'h7800, 16'h3C00, 16'h7800, 1'b0, 5'd0, 1'b1};
        vecs[13] = '{16'h0400, 16'h8401, 16'h8000, 1'b1, 5'd0, 1'b0};
        vecs[14] = '{16'hFC00, 16'h3C00, 16'hFC00, 1'b1, 5'd0, 1'b1};
        vecs[15] = '{16'hC000, 16'h3C00, 16'hBC00, 1'b1, 5'd1, 1'b1};
        vecs[16] = '{16'h4000, 16'h4400, 16'h4600, 1'b0, 5'd0, 1'b1};

        rst   = 1'b1;
        numi1 = 16'h3C00;
        numi2 = 16'h3C00;
        tick();
        tick();
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        // Stage-1 and stage-2 debug fields for 0.5 + 0.5.
        numi1 = 16'h3800;
        numi2 = 16'h3800;
        tick();
        check("s1_exp1o", 64'(exp1o), 64'(5'b01110));
        check("s1_exp2o", 64'(exp2o), 64'(5'b01110));
        check("s1_expdiffo", 64'(expdiffo), 64'd0);
        check("s1_szo", 64'(szo), 64'd0);
        check("s1_ra", 64'(ra), 64'(5'b01110));
        check("s1_signs", 64'({sign1o, sign2o}), 64'd0);
        tick();
        check("s2_ans", 64'(ans), 64'h3C00);
        check("s2_rexpo", 64'(rexpo), 64'(5'b01111));
        check("s2_mro", 64'(mro), 64'(11'b10000000000));
        check("s2_flago", 64'(flago), 64'd0);
        check("s2_lambdao", 64'(lambdao), 64'd0);

        for (int i = 0; i < 17; i++) begin
            numi1 = vecs[i].a;
            numi2 = vecs[i].b;
            tick();
            tick();
            check($sformatf("vec%0d_ans", i), 64'(ans), 64'(vecs[i].sum));
            check($sformatf("vec%0d_flago", i), 64'(flago), 64'(vecs[i].flag));
            check($sformatf("vec%0d_rexpo", i), 64'(rexpo), 64'(vecs[i].sum[14:10]));
            check($sformatf("vec%0d_mro", i), 64'(mro),
                  64'({|vecs[i].sum[14:10], vecs[i].sum[9:0]}));
            if (vecs[i].chk_lam) begin
                check($sformatf("vec%0d_lambdao", i), 64'(lambdao), 64'(vecs[i].lam));
            end
        end

        // Back-to-back issue: one result per cycle, first pair swapped.
        numi1 = 16'h3C00;
        numi2 = 16'h4000;
        tick();
        check("pipe_szo", 64'(szo), 64'd1);
        check("pipe_ra", 64'(ra), 64'(5'b10000));
        numi1 = 16'h4000;
        numi2 = 16'h4400;
        tick();
        check("pipe_ans0", 64'(ans), 64'h4200);
        numi1 = 16'hC000;
        numi2 = 16'h3C00;
        tick();
        check("pipe_ans1", 64'(ans), 64'h4600);
        tick();
        check("pipe_ans2", 64'(ans), 64'hBC00);

        // Reset with two operations in flight.
        numi1 = 16'h3C00;
        numi2 = 16'h3C00;
        tick();
        numi1 = 16'h4000;
        numi2 = 16'h4000;
        tick();
        rst   = 1'b1;
        numi1 = 16'h4400;
        numi2 = 16'h4400;
        tick();
        check("midrst_outputs", all_outs(), 64'd0);
        rst   = 1'b0;
        numi1 = 16'h3C00;
        numi2 = 16'h3800;
        tick();
        check("midrst_no_stale", 64'(ans), 64'h0000);
        check("midrst_s1_exp1o", 64'(exp1o), 64'(5'b01111));
        tick();
        check("midrst_first_ans", 64'(ans), 64'h3E00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
